// File: rtl/return_stack_pkg.sv
// Shared definitions for the return-address stack: default sizes, NEXT-mux select encodings
// and the push/pop operation decode.
package return_stack_pkg;

    localparam int unsigned RSTACK_DATA_WIDTH = 16;
    localparam int unsigned RSTACK_DEPTH      = 16;

    // NEXT-address multiplexer select encodings; the stack feeds the pop source
    localparam logic [1:0] SEL_NEXT_POP  = 2'b00;
    localparam logic [1:0] SEL_NEXT_TOR  = 2'b01;
    localparam logic [1:0] SEL_NEXT_PROG = 2'b11;

    typedef enum logic [1:0] {
        OpHold = 2'b00,
        OpPop  = 2'b01,
        OpPush = 2'b10,
        OpSwap = 2'b11
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic push, input logic pop);
        return stack_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Backing store below the TOS register: synchronous write, asynchronous read.
module stack_ram
    import return_stack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RSTACK_DATA_WIDTH,
    parameter int unsigned ENTRIES    = RSTACK_DEPTH - 1,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [ENTRIES];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/return_stack.sv
// LIFO return-address stack with a registered TOS driving the NEXT mux pop input.
// Optional sticky overflow/underflow flags are built when RSTACK_ERR_EN is defined.
module return_stack
    import return_stack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RSTACK_DATA_WIDTH,
    parameter int unsigned DEPTH      = RSTACK_DEPTH,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    output logic [DATA_WIDTH-1:0] o_pop_data,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_overflow,
    output logic                  o_underflow,
    input  logic                  i_clr_err
);

    localparam logic [ADDR_WIDTH:0] CountOne  = 1;
    localparam logic [ADDR_WIDTH:0] CountTwo  = 2;
    localparam logic [ADDR_WIDTH:0] CountFull = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_tos;
    logic [DATA_WIDTH-1:0] w_tos_d;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   w_count_d;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_empty;
    logic                  w_full;
    stack_op_e             w_op;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CountFull);
    assign w_op      = decode_op(i_push, i_pop);
    assign w_wr_addr = ADDR_WIDTH'(r_count - CountOne);
    // Read address forced to 0 below two entries so the slot is never an uninitialised index
    assign w_rd_addr = (r_count >= CountTwo) ? ADDR_WIDTH'(r_count - CountTwo) : '0;

    stack_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ENTRIES    (DEPTH - 1),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_stack_ram (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (r_tos),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        w_tos_d   = r_tos;
        w_count_d = r_count;
        w_wr_en   = 1'b0;
        unique case (w_op)
            OpPush: begin
                if (!w_full) begin
                    w_wr_en   = !w_empty;
                    w_tos_d   = i_push_data;
                    w_count_d = r_count + CountOne;
                end
            end
            OpPop: begin
                if (!w_empty) begin
                    w_tos_d   = (r_count >= CountTwo) ? w_rd_data : '0;
                    w_count_d = r_count - CountOne;
                end
            end
            OpSwap: begin
                w_tos_d = i_push_data;
            end
            OpHold: begin
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tos   <= '0;
            r_count <= '0;
        end else begin
            r_tos   <= w_tos_d;
            r_count <= w_count_d;
        end
    end

`ifdef RSTACK_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Clear wins over a same-cycle set
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_clr_err) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_op == OpPush && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_op == OpPop && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;
`else
    logic w_unused_clr_err;

    assign w_unused_clr_err = i_clr_err;
    assign o_overflow       = 1'b0;
    assign o_underflow      = 1'b0;
`endif

    assign o_pop_data = r_tos;
    assign o_count    = r_count;
    assign o_empty    = w_empty;
    assign o_full     = w_full;

endmodule
